// File: rtl/ice40_ram_arbiter.sv
// ice40_ram_arbiter: shares one 256x16 iCE40 block RAM between two requesters with independent read/write arbitration
module SB_RAM40_4K #(
    parameter logic [1:0]   READ_MODE  = 2'd0,
    parameter logic [1:0]   WRITE_MODE = 2'd0,
    parameter logic [255:0] INIT_0 = 256'h0,
    parameter logic [255:0] INIT_1 = 256'h0,
    parameter logic [255:0] INIT_2 = 256'h0,
    parameter logic [255:0] INIT_3 = 256'h0,
    parameter logic [255:0] INIT_4 = 256'h0,
    parameter logic [255:0] INIT_5 = 256'h0,
    parameter logic [255:0] INIT_6 = 256'h0,
    parameter logic [255:0] INIT_7 = 256'h0,
    parameter logic [255:0] INIT_8 = 256'h0,
    parameter logic [255:0] INIT_9 = 256'h0,
    parameter logic [255:0] INIT_A = 256'h0,
    parameter logic [255:0] INIT_B = 256'h0,
    parameter logic [255:0] INIT_C = 256'h0,
    parameter logic [255:0] INIT_D = 256'h0,
    parameter logic [255:0] INIT_E = 256'h0,
    parameter logic [255:0] INIT_F = 256'h0
) (
    output logic [15:0] RDATA,
    input  logic [10:0] RADDR,
    input  logic        RCLK,
    input  logic        RCLKE,
    input  logic        RE,
    input  logic [10:0] WADDR,
    input  logic        WCLK,
    input  logic        WCLKE,
    input  logic        WE,
    input  logic [15:0] WDATA,
    input  logic [15:0] MASK
);
    logic [4095:0] mem = {INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A, INIT_9, INIT_8,
                          INIT_7, INIT_6, INIT_5, INIT_4, INIT_3, INIT_2, INIT_1, INIT_0};
    logic [7:0] unused_bits;
    assign unused_bits = {RADDR[10:8], WADDR[10:8], READ_MODE[0] ^ READ_MODE[1], WRITE_MODE[0] ^ WRITE_MODE[1]};
    // synchronous read, data appears the cycle after RE
    always_ff @(posedge RCLK) begin
        if (RCLKE && RE) RDATA <= mem[{RADDR[7:0], 4'h0} +: 16];
    end
    // bit-masked write; a set MASK bit keeps the old data bit
    always_ff @(posedge WCLK) begin
        if (WCLKE && WE) mem[{WADDR[7:0], 4'h0} +: 16] <= (mem[{WADDR[7:0], 4'h0} +: 16] & MASK) | (WDATA & ~MASK);
    end
endmodule

module ice40_ram_arbiter #(
    parameter logic [255:0] INIT_0 = 256'h0,
    parameter logic [255:0] INIT_1 = 256'h0,
    parameter logic [255:0] INIT_2 = 256'h0,
    parameter logic [255:0] INIT_3 = 256'h0,
    parameter logic [255:0] INIT_4 = 256'h0,
    parameter logic [255:0] INIT_5 = 256'h0,
    parameter logic [255:0] INIT_6 = 256'h0,
    parameter logic [255:0] INIT_7 = 256'h0,
    parameter logic [255:0] INIT_8 = 256'h0,
    parameter logic [255:0] INIT_9 = 256'h0,
    parameter logic [255:0] INIT_A = 256'h0,
    parameter logic [255:0] INIT_B = 256'h0,
    parameter logic [255:0] INIT_C = 256'h0,
    parameter logic [255:0] INIT_D = 256'h0,
    parameter logic [255:0] INIT_E = 256'h0,
    parameter logic [255:0] INIT_F = 256'h0,
    parameter bit           RR_EN  = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        A_VALID,
    input  logic        A_WE,
    input  logic [7:0]  A_ADDR,
    input  logic [15:0] A_WDATA,
    input  logic [15:0] A_MASK,
    output logic        A_READY,
    output logic        A_RVALID,
    output logic [15:0] A_RDATA,
    input  logic        B_VALID,
    input  logic        B_WE,
    input  logic [7:0]  B_ADDR,
    input  logic [15:0] B_WDATA,
    input  logic [15:0] B_MASK,
    output logic        B_READY,
    output logic        B_RVALID,
    output logic [15:0] B_RDATA
);
    logic        rd_a, rd_b, wr_a, wr_b;
    logic        rd_sel_b, wr_sel_b, rd_go, wr_go, hazard;
    logic        pref_rd, pref_wr, rvalid_a, rvalid_b;
    logic [7:0]  rd_addr, wr_addr;
    logic [15:0] wr_data, wr_mask, ram_rdata;
    // request decode, per-port winner selection and read-behind-write stall
    always_comb begin
        rd_a     = A_VALID & ~A_WE;
        rd_b     = B_VALID & ~B_WE;
        wr_a     = A_VALID & A_WE;
        wr_b     = B_VALID & B_WE;
        rd_sel_b = rd_b & (~rd_a | (RR_EN & pref_rd));
        wr_sel_b = wr_b & (~wr_a | (RR_EN & pref_wr));
        rd_addr  = rd_sel_b ? B_ADDR : A_ADDR;
        wr_addr  = wr_sel_b ? B_ADDR : A_ADDR;
        wr_data  = wr_sel_b ? B_WDATA : A_WDATA;
        wr_mask  = wr_sel_b ? B_MASK : A_MASK;
        wr_go    = (wr_a | wr_b) & ~RESET;
        hazard   = wr_go & (rd_addr == wr_addr);
        rd_go    = (rd_a | rd_b) & ~hazard & ~RESET;
    end
    assign A_READY  = (rd_go & ~rd_sel_b) | (wr_go & ~wr_sel_b);
    assign B_READY  = (rd_go & rd_sel_b) | (wr_go & wr_sel_b);
    assign A_RVALID = rvalid_a & ~RESET;
    assign B_RVALID = rvalid_b & ~RESET;
    assign A_RDATA  = ram_rdata;
    assign B_RDATA  = ram_rdata;
    // preferences flip away from each granted requester; read responses tracked one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pref_rd  <= 1'b0;
            pref_wr  <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            pref_rd  <= rd_go ? ~rd_sel_b : pref_rd;
            pref_wr  <= wr_go ? ~wr_sel_b : pref_wr;
            rvalid_a <= rd_go & ~rd_sel_b;
            rvalid_b <= rd_go & rd_sel_b;
        end
    end
    SB_RAM40_4K #(
        .READ_MODE(2'd0), .WRITE_MODE(2'd0),
        .INIT_0(INIT_0), .INIT_1(INIT_1), .INIT_2(INIT_2), .INIT_3(INIT_3),
        .INIT_4(INIT_4), .INIT_5(INIT_5), .INIT_6(INIT_6), .INIT_7(INIT_7),
        .INIT_8(INIT_8), .INIT_9(INIT_9), .INIT_A(INIT_A), .INIT_B(INIT_B),
        .INIT_C(INIT_C), .INIT_D(INIT_D), .INIT_E(INIT_E), .INIT_F(INIT_F)
    ) ram (
        .RDATA(ram_rdata),
        .RADDR({3'b000, rd_addr}),
        .RCLK(CLK),
        .RCLKE(1'b1),
        .RE(rd_go),
        .WADDR({3'b000, wr_addr}),
        .WCLK(CLK),
        .WCLKE(1'b1),
        .WE(wr_go),
        .WDATA(wr_data),
        .MASK(wr_mask)
    );
endmodule
